// File: rtl/rf_port_scheduler.sv
// rf_port_scheduler: arbitrates the register file's shared A port between one
// pending read and buffered writebacks from the ALU (wb0) and memory (wb1).
// Optional feature macro: RF_SCHED_BYPASS_EN. When defined, a read that hits
// buffered data is served at once from the buffer instead of waiting for it
// to drain.
module rf_port_scheduler #(
   parameter int unsigned MAX_WR_BURST = 4
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic        rd_req,
   input  logic [3:0]  rd_addr_a,
   input  logic [3:0]  rd_addr_b,
   output logic        rd_gnt,
   output logic [31:0] rd_data_a,
   output logic [31:0] rd_data_b,
   input  logic        wb0_valid,
   input  logic        wb1_valid,
   input  logic [3:0]  wb0_addr,
   input  logic [3:0]  wb1_addr,
   input  logic [31:0] wb0_data,
   input  logic [31:0] wb1_data,
   output logic        wb0_ready,
   output logic        wb1_ready,
   output logic [3:0]  rf_addr_a,
   output logic [3:0]  rf_addr_b,
   output logic [31:0] rf_data,
   output logic        rf_rw,
   input  logic [31:0] rf_out_a,
   input  logic [31:0] rf_out_b
);

   localparam logic [3:0] C_MAX_BURST = 4'(MAX_WR_BURST);

   typedef enum logic [1:0] {SLOT_IDLE, SLOT_READ, SLOT_WRITE} slot_t;

   logic        r_buf0_valid, r_buf1_valid;
   logic [3:0]  r_buf0_addr,  r_buf1_addr;
   logic [31:0] r_buf0_data,  r_buf1_data;
   logic        r_rr;
   logic [3:0]  r_burst_cnt;

   logic        w_match0, w_match1, w_hazard, w_any_valid;
   logic        w_wr_sel;
   slot_t       w_slot;
   logic [31:0] w_rd_a, w_rd_b;

   assign w_match0    = r_buf0_valid && (r_buf0_addr == rd_addr_a || r_buf0_addr == rd_addr_b);
   assign w_match1    = r_buf1_valid && (r_buf1_addr == rd_addr_a || r_buf1_addr == rd_addr_b);
   assign w_hazard    = rd_req && (w_match0 || w_match1);
   assign w_any_valid = r_buf0_valid || r_buf1_valid;

   // Slot decision for the shared A port this cycle.
   always_comb begin
      w_slot = SLOT_IDLE;
      if (CLR)
         w_slot = SLOT_IDLE;
      else if (!w_any_valid)
         w_slot = rd_req ? SLOT_READ : SLOT_IDLE;
`ifdef RF_SCHED_BYPASS_EN
      else if (w_hazard)
         w_slot = SLOT_READ;
`endif
      else if (rd_req && !w_hazard && r_burst_cnt == C_MAX_BURST)
         w_slot = SLOT_READ;
      else
         w_slot = SLOT_WRITE;
   end

   // Write source: a lone valid buffer, else the single hazard match, else rr.
   always_comb begin
      w_wr_sel = r_rr;
      if (!r_buf1_valid)
         w_wr_sel = 1'b0;
      else if (!r_buf0_valid)
         w_wr_sel = 1'b1;
      else if (w_hazard && w_match0 && !w_match1)
         w_wr_sel = 1'b0;
      else if (w_hazard && w_match1 && !w_match0)
         w_wr_sel = 1'b1;
   end

`ifdef RF_SCHED_BYPASS_EN
   logic w_hit0_a, w_hit1_a, w_hit0_b, w_hit1_b;
   assign w_hit0_a = r_buf0_valid && r_buf0_addr == rd_addr_a;
   assign w_hit1_a = r_buf1_valid && r_buf1_addr == rd_addr_a;
   assign w_hit0_b = r_buf0_valid && r_buf0_addr == rd_addr_b;
   assign w_hit1_b = r_buf1_valid && r_buf1_addr == rd_addr_b;

   // Forward buffered data; on a double hit the later-written buffer (!rr) wins.
   always_comb begin
      w_rd_a = rf_out_a;
      w_rd_b = rf_out_b;
      if (w_hit0_a && w_hit1_a)
         w_rd_a = r_rr ? r_buf0_data : r_buf1_data;
      else if (w_hit0_a)
         w_rd_a = r_buf0_data;
      else if (w_hit1_a)
         w_rd_a = r_buf1_data;
      if (w_hit0_b && w_hit1_b)
         w_rd_b = r_rr ? r_buf0_data : r_buf1_data;
      else if (w_hit0_b)
         w_rd_b = r_buf0_data;
      else if (w_hit1_b)
         w_rd_b = r_buf1_data;
   end
`else
   assign w_rd_a = rf_out_a;
   assign w_rd_b = rf_out_b;
`endif

   assign rd_gnt    = (w_slot == SLOT_READ);
   assign rd_data_a = rd_gnt ? w_rd_a : 32'h0;
   assign rd_data_b = rd_gnt ? w_rd_b : 32'h0;
   assign rf_rw     = (w_slot != SLOT_WRITE);
   assign rf_addr_b = rd_addr_b;
   assign rf_addr_a = (w_slot == SLOT_WRITE) ? (w_wr_sel ? r_buf1_addr : r_buf0_addr)
                    : (CLR ? 4'h0 : rd_addr_a);
   assign rf_data   = (w_slot == SLOT_WRITE) ? (w_wr_sel ? r_buf1_data : r_buf0_data) : 32'h0;
   // A buffer can take a new offer on the same edge it drains.
   assign wb0_ready = CLR || !r_buf0_valid || (w_slot == SLOT_WRITE && !w_wr_sel);
   assign wb1_ready = CLR || !r_buf1_valid || (w_slot == SLOT_WRITE &&  w_wr_sel);

   // Buffer fill/drain, round-robin pointer and write-burst counter.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         r_buf0_valid <= 1'b0;
         r_buf1_valid <= 1'b0;
         r_buf0_addr  <= 4'h0;
         r_buf1_addr  <= 4'h0;
         r_buf0_data  <= 32'h0;
         r_buf1_data  <= 32'h0;
         r_rr         <= 1'b0;
         r_burst_cnt  <= 4'h0;
      end else begin
         if (wb0_valid && wb0_ready) begin
            r_buf0_valid <= 1'b1;
            r_buf0_addr  <= wb0_addr;
            r_buf0_data  <= wb0_data;
         end else if (w_slot == SLOT_WRITE && !w_wr_sel) begin
            r_buf0_valid <= 1'b0;
         end
         if (wb1_valid && wb1_ready) begin
            r_buf1_valid <= 1'b1;
            r_buf1_addr  <= wb1_addr;
            r_buf1_data  <= wb1_data;
         end else if (w_slot == SLOT_WRITE && w_wr_sel) begin
            r_buf1_valid <= 1'b0;
         end
         if (w_slot == SLOT_WRITE && r_buf0_valid && r_buf1_valid)
            r_rr <= ~w_wr_sel;
         if (!rd_req || w_slot == SLOT_READ)
            r_burst_cnt <= 4'h0;
         else if (w_slot == SLOT_WRITE && r_burst_cnt != C_MAX_BURST)
            r_burst_cnt <= r_burst_cnt + 4'h1;
      end
   end

endmodule

// File: tb/tb_rf_port_scheduler.sv
// Bench for rf_port_scheduler: behavioural 16x32 register file, per-source
// write scoreboard and read-result scoreboard, plus scenario tasks.
module tb_rf_port_scheduler;

   logic        CLK = 1'b0;
   logic        CLR;
   logic        rd_req;
   logic [3:0]  rd_addr_a, rd_addr_b;
   logic        rd_gnt;
   logic [31:0] rd_data_a, rd_data_b;
   logic        wb0_valid, wb1_valid;
   logic [3:0]  wb0_addr, wb1_addr;
   logic [31:0] wb0_data, wb1_data;
   logic        wb0_ready, wb1_ready;
   logic [3:0]  rf_addr_a, rf_addr_b;
   logic [31:0] rf_data;
   logic        rf_rw;
   logic [31:0] rf_out_a, rf_out_b;

   logic [31:0] mem [16];
   logic [35:0] q_wr0[$], q_wr1[$];
   logic [31:0] q_rd_a[$], q_rd_b[$];
   int          n_pass = 0;
   int          n_chk  = 0;
   logic [31:0] ea, eb;

   always #5 CLK = ~CLK;

   rf_port_scheduler #(.MAX_WR_BURST(4)) dut (
      .CLK(CLK), .CLR(CLR), .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_gnt(rd_gnt), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .wb0_valid(wb0_valid), .wb1_valid(wb1_valid), .wb0_addr(wb0_addr), .wb1_addr(wb1_addr),
      .wb0_data(wb0_data), .wb1_data(wb1_data), .wb0_ready(wb0_ready), .wb1_ready(wb1_ready),
      .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_data(rf_data), .rf_rw(rf_rw),
      .rf_out_a(rf_out_a), .rf_out_b(rf_out_b)
   );

   assign rf_out_a = mem[rf_addr_a];
   assign rf_out_b = mem[rf_addr_b];

   always @(posedge CLK) begin
      if (rf_rw === 1'b0) mem[rf_addr_a] <= rf_data;
   end

   // Scoreboard: writes must leave each source in acceptance order; grants pop reads.
   always @(negedge CLK) begin
      if (CLR === 1'b0) begin
         if (rf_rw === 1'b0) begin
            n_chk++;
            if (q_wr0.size() != 0 && q_wr0[0] === {rf_addr_a, rf_data}) begin
               n_pass++;
               void'(q_wr0.pop_front());
            end else if (q_wr1.size() != 0 && q_wr1[0] === {rf_addr_a, rf_data}) begin
               n_pass++;
               void'(q_wr1.pop_front());
            end else
               $display("FAIL sb_write: got addr=%0d data=%h, not at head of either source queue",
                        rf_addr_a, rf_data);
         end
         if (wb0_valid && wb0_ready) q_wr0.push_back({wb0_addr, wb0_data});
         if (wb1_valid && wb1_ready) q_wr1.push_back({wb1_addr, wb1_data});
         if (rd_gnt === 1'b1) begin
            n_chk++;
            if (q_rd_a.size() == 0)
               $display("FAIL sb_read: got unexpected grant, expected none");
            else begin
               ea = q_rd_a.pop_front();
               eb = q_rd_b.pop_front();
               if (rd_data_a !== ea || rd_data_b !== eb)
                  $display("FAIL sb_read: got a=%h b=%h, expected a=%h b=%h",
                           rd_data_a, rd_data_b, ea, eb);
               else
                  n_pass++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_read(input logic [3:0] a, input logic [3:0] b,
                          input logic [31:0] xa, input logic [31:0] xb);
      bit got = 0;
      int n = 0;
      q_rd_a.push_back(xa);
      q_rd_b.push_back(xb);
      tick();
      rd_req = 1; rd_addr_a = a; rd_addr_b = b;
      while (!got && n < 20) begin
         @(negedge CLK);
         if (rd_gnt === 1'b1) got = 1;
         n++;
      end
      if (!got) begin
         n_chk++;
         $display("FAIL read_timeout: got no grant in 20 cycles, expected grant (R%0d)", a);
         q_rd_a.delete();
         q_rd_b.delete();
      end
      tick();
      rd_req = 0;
   endtask

   task automatic test_reset();
      logic [39:0] exp_v;
      CLR = 1; wb0_valid = 1; wb0_addr = 4'd2; wb0_data = 32'hBAD0BAD0;
      rd_req = 0; rd_addr_a = 4'd4; rd_addr_b = 4'd0;
      exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 32'h0};
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         n_chk++;
         if ({rf_rw, rd_gnt, wb0_ready, wb1_ready, rf_addr_a, rf_data} !== exp_v)
            $display("FAIL reset_outputs: got %h, expected %h",
                     {rf_rw, rd_gnt, wb0_ready, wb1_ready, rf_addr_a, rf_data}, exp_v);
         else n_pass++;
      end
      tick();
      CLR = 0; wb0_valid = 0;
      @(negedge CLK);
      n_chk++;
      if ({rf_rw, rd_gnt, wb0_ready, wb1_ready} !== 4'b1011)
         $display("FAIL reset_release: got rw/gnt/rdy0/rdy1=%b, expected 1011",
                  {rf_rw, rd_gnt, wb0_ready, wb1_ready});
      else n_pass++;
   endtask

   task automatic test_single_write();
      tick();
      wb0_valid = 1; wb0_addr = 4'd3; wb0_data = 32'hDEADBEEF;
      tick();
      wb0_valid = 0;
      @(negedge CLK);
      n_chk++;
      if ({rf_rw, rf_addr_a, rf_data} !== {1'b0, 4'd3, 32'hDEADBEEF})
         $display("FAIL single_write: got rw=%b addr=%0d data=%h, expected rw=0 addr=3 data=deadbeef",
                  rf_rw, rf_addr_a, rf_data);
      else n_pass++;
      do_read(4'd3, 4'd0, 32'hDEADBEEF, 32'h0);
   endtask

   task automatic tie(input logic [3:0] a0, input logic [31:0] d0,
                      input logic [3:0] a1, input logic [31:0] d1,
                      input logic [35:0] first, input logic [35:0] second);
      tick();
      wb0_valid = 1; wb0_addr = a0; wb0_data = d0;
      wb1_valid = 1; wb1_addr = a1; wb1_data = d1;
      tick();
      wb0_valid = 0; wb1_valid = 0;
      @(negedge CLK);
      n_chk++;
      if ({rf_rw, rf_addr_a, rf_data} !== {1'b0, first})
         $display("FAIL tie_first: got rw=%b addr=%0d data=%h, expected rw=0 %h",
                  rf_rw, rf_addr_a, rf_data, first);
      else n_pass++;
      @(negedge CLK);
      n_chk++;
      if ({rf_rw, rf_addr_a, rf_data} !== {1'b0, second})
         $display("FAIL tie_second: got rw=%b addr=%0d data=%h, expected rw=0 %h",
                  rf_rw, rf_addr_a, rf_data, second);
      else n_pass++;
   endtask

   task automatic test_tie();
      tie(4'd1, 32'h11, 4'd2, 32'h22, {4'd1, 32'h11}, {4'd2, 32'h22});
      tie(4'd4, 32'h44, 4'd6, 32'h66, {4'd6, 32'h66}, {4'd4, 32'h44});
      tie(4'd9, 32'hA0, 4'd9, 32'hB0, {4'd9, 32'hA0}, {4'd9, 32'hB0});
      do_read(4'd9, 4'd4, 32'hB0, 32'h44);
   endtask

   task automatic test_starvation();
      int  idx0 = 0, idx1 = 0;
      bit  acc0, acc1;
      logic [3:0] a0_tab [4];
      logic [3:0] a1_tab [4];
      a0_tab = '{4'd8, 4'd10, 4'd12, 4'd14};
      a1_tab = '{4'd11, 4'd13, 4'd15, 4'd8};
      tick();
      wb0_valid = 1; wb0_addr = 4'd7; wb0_data = 32'h77;
      tick();
      wb0_valid = 0;
      @(negedge CLK);
      q_rd_a.push_back(32'h77);
      q_rd_b.push_back(32'h11);
      tick();
      wb0_valid = 1; wb0_addr = a0_tab[0]; wb0_data = 32'hA000_0000;
      wb1_valid = 1; wb1_addr = a1_tab[0]; wb1_data = 32'hB000_0000;
      rd_req = 0;
      @(negedge CLK);
      acc0 = wb0_valid && wb0_ready;
      acc1 = wb1_valid && wb1_ready;
      for (int cyc = 1; cyc <= 5; cyc++) begin
         tick();
         if (acc0) begin
            idx0++;
            wb0_addr = a0_tab[idx0 % 4]; wb0_data = 32'hA000_0000 + 32'(idx0);
         end
         if (acc1) begin
            idx1++;
            wb1_addr = a1_tab[idx1 % 4]; wb1_data = 32'hB000_0000 + 32'(idx1);
         end
         rd_req = 1; rd_addr_a = 4'd7; rd_addr_b = 4'd1;
         @(negedge CLK);
         acc0 = wb0_valid && wb0_ready;
         acc1 = wb1_valid && wb1_ready;
         n_chk++;
         if (rd_gnt !== (cyc == 5))
            $display("FAIL starve_gnt: cycle %0d got rd_gnt=%b, expected %b", cyc, rd_gnt, cyc == 5);
         else n_pass++;
      end
      tick();
      rd_req = 0; wb0_valid = 0; wb1_valid = 0;
      repeat (3) @(negedge CLK);
   endtask

   task automatic test_hazard();
      tick();
      wb0_valid = 1; wb0_addr = 4'd5; wb0_data = 32'h55;
      q_rd_a.push_back(32'h55);
      q_rd_b.push_back(32'hDEADBEEF);
      tick();
      wb0_valid = 0;
      rd_req = 1; rd_addr_a = 4'd5; rd_addr_b = 4'd3;
      @(negedge CLK);
      n_chk++;
`ifdef RF_SCHED_BYPASS_EN
      if ({rd_gnt, rf_rw, rd_data_a} !== {1'b1, 1'b1, 32'h55})
         $display("FAIL hazard_bypass: got gnt=%b rw=%b data_a=%h, expected gnt=1 rw=1 data_a=55",
                  rd_gnt, rf_rw, rd_data_a);
      else n_pass++;
      tick();
      rd_req = 0;
      @(negedge CLK);
      n_chk++;
      if ({rf_rw, rf_addr_a, rf_data} !== {1'b0, 4'd5, 32'h55})
         $display("FAIL hazard_late_wr: got rw=%b addr=%0d data=%h, expected rw=0 addr=5 data=55",
                  rf_rw, rf_addr_a, rf_data);
      else n_pass++;
`else
      if ({rd_gnt, rf_rw, rf_addr_a} !== {1'b0, 1'b0, 4'd5})
         $display("FAIL hazard_stall: got gnt=%b rw=%b addr=%0d, expected gnt=0 rw=0 addr=5",
                  rd_gnt, rf_rw, rf_addr_a);
      else n_pass++;
      @(negedge CLK);
      n_chk++;
      if ({rd_gnt, rd_data_a} !== {1'b1, 32'h55})
         $display("FAIL hazard_read: got gnt=%b data_a=%h, expected gnt=1 data_a=55",
                  rd_gnt, rd_data_a);
      else n_pass++;
      tick();
      rd_req = 0;
`endif
   endtask

   task automatic test_hazard_override();
      tick();
      CLR = 1;
      tick();
      CLR = 0;
      wb0_valid = 1; wb0_addr = 4'd10; wb0_data = 32'hA;
      wb1_valid = 1; wb1_addr = 4'd12; wb1_data = 32'hC;
      q_rd_a.push_back(32'hC);
      q_rd_b.push_back(32'h0);
      tick();
      wb0_valid = 0; wb1_valid = 0;
      rd_req = 1; rd_addr_a = 4'd12; rd_addr_b = 4'd0;
      @(negedge CLK);
      n_chk++;
`ifdef RF_SCHED_BYPASS_EN
      if ({rd_gnt, rf_rw, rd_data_a} !== {1'b1, 1'b1, 32'hC})
         $display("FAIL override_bypass: got gnt=%b rw=%b data_a=%h, expected gnt=1 rw=1 data_a=c",
                  rd_gnt, rf_rw, rd_data_a);
      else n_pass++;
      tick();
      rd_req = 0;
      repeat (2) @(negedge CLK);
`else
      if ({rd_gnt, rf_rw, rf_addr_a} !== {1'b0, 1'b0, 4'd12})
         $display("FAIL override_first: got gnt=%b rw=%b addr=%0d, expected gnt=0 rw=0 addr=12",
                  rd_gnt, rf_rw, rf_addr_a);
      else n_pass++;
      @(negedge CLK);
      n_chk++;
      if ({rd_gnt, rf_rw, rf_addr_a} !== {1'b0, 1'b0, 4'd10})
         $display("FAIL override_second: got gnt=%b rw=%b addr=%0d, expected gnt=0 rw=0 addr=10",
                  rd_gnt, rf_rw, rf_addr_a);
      else n_pass++;
      @(negedge CLK);
      n_chk++;
      if ({rd_gnt, rf_rw, rf_addr_a} !== {1'b1, 1'b1, 4'd12})
         $display("FAIL override_read: got gnt=%b rw=%b addr=%0d, expected gnt=1 rw=1 addr=12",
                  rd_gnt, rf_rw, rf_addr_a);
      else n_pass++;
      tick();
      rd_req = 0;
`endif
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      CLR = 1; rd_req = 0; rd_addr_a = 0; rd_addr_b = 0;
      wb0_valid = 0; wb1_valid = 0; wb0_addr = 0; wb1_addr = 0; wb0_data = 0; wb1_data = 0;
      test_reset();
      test_single_write();
      test_tie();
      test_starvation();
      test_hazard();
      test_hazard_override();
      repeat (3) @(negedge CLK);
      n_chk++;
      if (q_wr0.size() + q_wr1.size() + q_rd_a.size() != 0)
         $display("FAIL drain: got %0d entries left in scoreboards, expected 0",
                  q_wr0.size() + q_wr1.size() + q_rd_a.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rf_port_scheduler.md
# rf_port_scheduler

Sequencer for the 16x32 register file's shared A port. That port carries either a write (addressA + inputData, RW=0) or a read-A (addressA, RW=1) in a given cycle, never both. The block buffers writeback traffic from two sources (ALU, memory), arbitrates each cycle between one pending read and those writes, and detects read-after-write hazards against buffered data. It sits between the pipeline writeback/decode stages and the register file.

## Interface
- MAX_WR_BURST, default 4: consecutive write cycles allowed while a non-hazard read waits; legal range 1..15.
- CLK  input  1  clock, all state updates on rising edge.
- CLR  input  1  reset, synchronous, active-high.
- rd_req  input  1  read request, held until granted.
- rd_addr_a, rd_addr_b  input  4  read operand addresses.
- rd_gnt  output  1  read served this cycle; rd_data_a/b valid this cycle.
- rd_data_a, rd_data_b  output  32  read results.
- wb0_valid, wb1_valid  input  1  write offers (0 = ALU, 1 = memory).
- wb0_addr, wb1_addr  input  4  destination registers.
- wb0_data, wb1_data  input  32  write data.
- wb0_ready, wb1_ready  output  1  offer accepted on this edge when valid&ready.
- rf_addr_a, rf_addr_b  output  4  to register file addressA/addressB.
- rf_data  output  32  to register file inputData.
- rf_rw  output  1  to register file RW; 1 = read, 0 = write.
- rf_out_a, rf_out_b  input  32  register file outA/outB.

## Operation
- One holding buffer per source: valid, addr[3:0], data[31:0].
- wbN_ready = !bufN_valid || (write slot this cycle selects bufN). Same-cycle drain and refill is allowed, giving 1 write/cycle per source.
- Hazard is true when rd_req=1 and any valid buffer addr equals rd_addr_a or rd_addr_b.
- Per-cycle slot decision, evaluated in order:
  1. CLR=1 → idle.
  2. No valid buffer → read if rd_req, else idle.
  3. rd_req && !hazard && burst_cnt==MAX_WR_BURST → read.
  4. Otherwise → write.
- Write source selection:
  - Only one buffer valid → that buffer.
  - Both valid → round-robin pointer `rr`. After reset rr=0, so wb0 wins the first tie. rr flips to the other source after every write served from a tie.
  - When a hazard exists and only one buffer matches, the matching buffer is written first, overriding rr.
- Write slot:
  - rf_rw=0, rf_addr_a=buf.addr, rf_data=buf.data.
  - Selected buffer clears at the edge, unless it is refilled on the same edge.
- Read slot:
  - rf_rw=1, rf_addr_a=rd_addr_a, rd_gnt=1.
  - rd_data_a=rf_out_a, rd_data_b=rf_out_b.
- Idle slot: rf_rw=1, rf_addr_a=rd_addr_a, rd_gnt=0.
- rf_addr_b=rd_addr_b always.
- burst_cnt (4 bits):
  - Increments on a write slot while rd_req=1, saturating at MAX_WR_BURST.
  - Clears on a read slot or when rd_req=0.
- A buffered write to address X followed by a read of X must return the new data, via stall or bypass.
- Both sources may target the same address in one tie. Write order follows rr; the later write wins.

## Timing
- Reset values (CLR=1, at the edge and during that cycle):
  - Buffers cleared, rr=0, burst_cnt=0.
  - wb0_ready=wb1_ready=1 (offers are ignored while CLR=1).
  - rd_gnt=0, rf_rw=1, rf_addr_a=0, rf_data=0, rd_data_a/b=0.
- Slot outputs are combinational from registered state plus rd_req/rd_addr. The register file commits the write on the same rising edge.
- Write latency: accepted at edge E, earliest rf write at edge E+1.
- Read latency: same cycle as rd_gnt.
- Worst-case read stall with no hazard: MAX_WR_BURST cycles. With a hazard, the stall lasts until the matching buffers drain, at most 2 cycles if no new matching writes arrive.
- CLR asserted mid-operation: buffered, unwritten data is discarded and no rf write occurs in that cycle.

## Configuration
- RF_SCHED_BYPASS_EN defined: on a hazard, a read slot may be taken without draining. rd_data_a/b take the matching buffer's data in place of rf_out. If both buffers match, the one to be written later in rr order supplies the data. The hazard then no longer forces a write.
- Undefined: hazards stall reads as in Operation; rd_data_a/b are always rf_out_a/b.

## Test plan
- Reset: CLR=1 for 2 cycles with wb0_valid=1 → no rf_rw=0 cycles, rd_gnt=0, both ready=1 after release.
- Single write: wb0 addr=3 data=0xDEADBEEF at edge E → rf_rw=0, rf_addr_a=3, rf_data=0xDEADBEEF in cycle E+1; a later read of R3 returns 0xDEADBEEF.
- Tie: wb0 (R1=0x11) and wb1 (R2=0x22) offered together → R1 written first, then R2; the next tie starts with wb1.
- Starvation: wb0/wb1 streaming continuous non-hazard writes, rd_req=1 reading R7 → with MAX_WR_BURST=4, rd_gnt=1 on the 5th cycle.
- Hazard without bypass: buffer holds R5=0x55, read R5 → rd_gnt=0 for one cycle, then rd_data_a=0x55.
- Hazard with RF_SCHED_BYPASS_EN: same stimulus → rd_gnt=1 in the first cycle with rd_data_a=0x55, and the R5 write still occurs afterwards.
